// File: rtl/pipe_add_sub_pkg.sv
// Shared ALU definitions for the sCORE datapath: op encoding and saturation bounds.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sCORE_alu_pkg;

    // Operation encoding carried on the input_sub port
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the saturation helpers support; callers truncate to their width
    localparam int SAT_MAX_W = 1024;

    // Largest positive two's-complement value of width w: 0111..1
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
        logic [SAT_MAX_W-1:0] one;
        one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        return (one << (w - 1)) - one;
    endfunction

    // Most negative two's-complement value of width w: 1000..0
    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w);
        logic [SAT_MAX_W-1:0] one;
        one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/pipe_add_sub_add_slice.sv
// Combinational W-bit slice of the split carry chain: a + b + cin.
// Latency: 0 cycles (purely combinational, registered by the caller).
// Backpressure: none; the enclosing pipeline owns the handshake.
module add_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [W:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    assign sum_o  = full[W-1:0];
    assign cout_o = full[W];
    // Carry into the top bit recovered from the top bit's own sum equation
    assign cmsb_o = a_i[W-1] ^ b_i[W-1] ^ full[W-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit add/sub; carry chain cut into STAGES slices of WIDTH/STAGES bits.
// Latency: STAGES cycles accept-to-output_valid, 1 op/cycle, up to STAGES ops in flight.
// Backpressure: global stall -- whole pipe holds while output_valid && !output_ready.
// Optional: define PIPE_ADD_SAT_EN for signed saturation on overflow (default wraps).
// WIDTH must be a multiple of STAGES.
module pipe_add_sub
    import sCORE_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             input_clk,
    input  logic             input_reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_carry,
    input  logic             input_sub,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [WIDTH-1:0] output_sum,
    output logic             output_carry,
    output logic             output_ovf,
    output logic             output_zero
);

    localparam int CHUNK = WIDTH / STAGES;

    // Per-stage registers; index STAGES-1 is the output register
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             cy_q  [STAGES];
    logic             ovf_q;
    logic             zero_q;

    // Inputs seen by each stage's slice adder (ports for stage 0, prior register otherwise)
    logic             st_vld [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic             st_cin [STAGES];

    // Slice adder results and next-state values
    logic [CHUNK-1:0] sl_sum  [STAGES];
    logic             sl_cout [STAGES];
    logic             sl_cmsb [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             ovf_d;
    logic             zero_d;

    logic adv;

    assign adv          = !vld_q[STAGES-1] || output_ready;
    assign input_ready  = adv;

    assign output_valid = vld_q[STAGES-1];
    assign output_sum   = sum_q[STAGES-1];
    assign output_carry = cy_q[STAGES-1];
    assign output_ovf   = ovf_q;
    assign output_zero  = zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // B is inverted once on entry; later stages only ever see B'
            assign st_vld[k] = input_valid;
            assign st_a[k]   = input_a;
            assign st_b[k]   = (input_sub == OP_ADD) ? input_b : ~input_b;
            assign st_sum[k] = '0;
            assign st_cin[k] = (input_sub == OP_SUB) ? 1'b1 : input_carry;
        end else begin : g_next
            assign st_vld[k] = vld_q[k-1];
            assign st_a[k]   = a_q[k-1];
            assign st_b[k]   = b_q[k-1];
            assign st_sum[k] = sum_q[k-1];
            assign st_cin[k] = cy_q[k-1];
        end

        add_slice #(
            .W (CHUNK)
        ) u_slice (
            .a_i    (st_a[k][k*CHUNK +: CHUNK]),
            .b_i    (st_b[k][k*CHUNK +: CHUNK]),
            .cin_i  (st_cin[k]),
            .sum_o  (sl_sum[k]),
            .cout_o (sl_cout[k]),
            .cmsb_o (sl_cmsb[k])
        );

        if (k < STAGES - 1) begin : g_mid
            // Slices above k are still zero, so OR drops the new slice into place
            assign sum_d[k] = st_sum[k] | (WIDTH'(sl_sum[k]) << (k * CHUNK));
        end else begin : g_last
            logic [WIDTH-1:0] full_sum;
            logic [WIDTH-1:0] res;

            assign full_sum = st_sum[k] | (WIDTH'(sl_sum[k]) << (k * CHUNK));
            assign ovf_d    = sl_cmsb[k] ^ sl_cout[k];
`ifdef PIPE_ADD_SAT_EN
            // On overflow the true result's sign is the sign of A
            assign res = !ovf_d          ? full_sum :
                         st_a[k][WIDTH-1] ? WIDTH'(sat_min(WIDTH)) :
                                            WIDTH'(sat_max(WIDTH));
`else
            assign res = full_sum;
`endif
            assign sum_d[k] = res;
            assign zero_d   = (res == '0);
        end
    end

    // All stages advance together on adv, or all hold; reset drops every in-flight op
    always_ff @(posedge input_clk or posedge input_reset) begin
        if (input_reset) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                cy_q[k]  <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= st_vld[k];
                a_q[k]   <= st_a[k];
                b_q[k]   <= st_b[k];
                sum_q[k] <= sum_d[k];
                cy_q[k]  <= sl_cout[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipe_add_sub.sv
module tb_pipe_add_sub;

    typedef struct packed {
        logic        z;
        logic        ovf;
        logic        c;
        logic [31:0] s;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=8 STAGES=2 instance for directed cases
    logic       iv8 = 0, or8 = 0, cin8 = 0, sub8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       rdy8, ov8, c8, ovf8, z8;
    logic [7:0] s8;

    // WIDTH=32 STAGES=4 and STAGES=1 instances for random traffic
    logic        ivx = 0, orx = 0, cinx = 0, subx = 0;
    logic [31:0] ax = 0, bx = 0;
    logic        rdyx, ovx, cx, ovfx, zx;
    logic [31:0] sx;
    logic        ivy = 0, ory = 0, ciny = 0, suby = 0;
    logic [31:0] ay = 0, by = 0;
    logic        rdyy, ovy, cy, ovfy, zy;
    logic [31:0] sy;

    pipe_add_sub #(.WIDTH(8), .STAGES(2)) u_d8 (
        .input_clk(clk), .input_reset(rst), .input_valid(iv8), .input_ready(rdy8),
        .input_a(a8), .input_b(b8), .input_carry(cin8), .input_sub(sub8),
        .output_valid(ov8), .output_ready(or8), .output_sum(s8), .output_carry(c8),
        .output_ovf(ovf8), .output_zero(z8));

    pipe_add_sub #(.WIDTH(32), .STAGES(4)) u_dx (
        .input_clk(clk), .input_reset(rst), .input_valid(ivx), .input_ready(rdyx),
        .input_a(ax), .input_b(bx), .input_carry(cinx), .input_sub(subx),
        .output_valid(ovx), .output_ready(orx), .output_sum(sx), .output_carry(cx),
        .output_ovf(ovfx), .output_zero(zx));

    pipe_add_sub #(.WIDTH(32), .STAGES(1)) u_dy (
        .input_clk(clk), .input_reset(rst), .input_valid(ivy), .input_ready(rdyy),
        .input_a(ay), .input_b(by), .input_carry(ciny), .input_sub(suby),
        .output_valid(ovy), .output_ready(ory), .output_sum(sy), .output_carry(cy),
        .output_ovf(ovfy), .output_zero(zy));

    res_t q8[$];
    res_t qx[$];
    res_t qy[$];

    // Reference: w-bit two's-complement arithmetic on plain integers
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic c, logic sub);
        logic [63:0] mask, av, bp, full;
        logic        sa, sb, ss;
        res_t        r;
        mask  = (64'd1 << w) - 64'd1;
        av    = {32'd0, a} & mask;
        bp    = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        full  = av + bp + (sub ? 64'd1 : {63'd0, c});
        r.s   = 32'(full & mask);
        r.c   = full[w];
        sa    = av[w-1];
        sb    = bp[w-1];
        ss    = full[w-1];
        r.ovf = (sa == sb) && (ss != sa);
`ifdef PIPE_ADD_SAT_EN
        if (r.ovf) r.s = sa ? 32'(64'd1 << (w - 1)) : 32'((64'd1 << (w - 1)) - 64'd1);
`endif
        r.z   = (r.s == 32'd0);
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One op through the 8-bit pipe with the consumer always ready
    task automatic do_op8(string tag, logic [7:0] a, logic [7:0] b, logic c, logic sub, res_t exp);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; sub8 = sub; iv8 = 1'b1; or8 = 1'b1;
        #1 chk({tag, "_rdy"}, 64'(rdy8), 64'd1);
        @(negedge clk);
        iv8 = 1'b0;
        #1 chk({tag, "_early"}, 64'(ov8), 64'd0);
        @(negedge clk);
        #1 chk({tag, "_vld"}, 64'(ov8), 64'd1);
        chk(tag, 64'(res_t'{z8, ovf8, c8, {24'd0, s8}}), 64'(exp));
    endtask

    logic [7:0] oa [5];
    logic [7:0] ob [5];
    logic       os [5];
    logic [7:0] held8;
    int         sent, got, stale;
    logic       hx, hy;
    res_t       hvx, hvy, obs;

    initial begin
        // Reset state
        #1;
        chk("rst_out8", 64'({ov8, res_t'{z8, ovf8, c8, {24'd0, s8}}}), 64'd0);
        chk("rst_rdy8", 64'(rdy8), 64'd1);
        chk("rst_vld32", 64'({ovx, ovy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases
        do_op8("t1_ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0, res_t'{1'b1, 1'b0, 1'b1, 32'h00});
        do_op8("t2_5_minus_7", 8'h05, 8'h07, 1'b0, 1'b1, res_t'{1'b0, 1'b0, 1'b0, 32'hFE});
        do_op8("t2_7_minus_5", 8'h07, 8'h05, 1'b0, 1'b1, res_t'{1'b0, 1'b0, 1'b1, 32'h02});
        do_op8("t2_cin_ignored", 8'h07, 8'h05, 1'b1, 1'b1, res_t'{1'b0, 1'b0, 1'b1, 32'h02});
        do_op8("t1_cin_add", 8'h10, 8'h20, 1'b1, 1'b0, res_t'{1'b0, 1'b0, 1'b0, 32'h31});
`ifdef PIPE_ADD_SAT_EN
        do_op8("t3_pos_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, res_t'{1'b0, 1'b1, 1'b0, 32'h7F});
        do_op8("t3_neg_ovf", 8'h80, 8'h01, 1'b0, 1'b1, res_t'{1'b0, 1'b1, 1'b1, 32'h80});
`else
        do_op8("t3_pos_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, res_t'{1'b0, 1'b1, 1'b0, 32'h80});
        do_op8("t3_neg_ovf", 8'h80, 8'h01, 1'b0, 1'b1, res_t'{1'b0, 1'b1, 1'b1, 32'h7F});
`endif

        // Back-to-back stream with the consumer stalled, then released
        for (int i = 0; i < 5; i++) begin
            oa[i] = 8'($urandom);
            ob[i] = 8'($urandom);
            os[i] = 1'(i % 2);
        end
        sent = 0; got = 0; held8 = 8'd0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge clk);
            iv8 = (sent < 5);
            if (sent < 5) begin
                a8 = oa[sent]; b8 = ob[sent]; sub8 = os[sent]; cin8 = 1'b0;
            end
            or8 = (cyc >= 6);
            #1;
            if (cyc == 3) held8 = s8;
            if (cyc == 4) chk("t4_full_rdy", 64'({ov8, rdy8}), 64'b10);
            if (cyc == 5) chk("t4_hold_sum", 64'(s8), 64'(held8));
            if (ov8 && or8) begin
                if (q8.size() == 0) chk("t4_extra", 64'(ov8), 64'd0);
                else begin
                    chk("t4_order", 64'(res_t'{z8, ovf8, c8, {24'd0, s8}}), 64'(q8.pop_front()));
                    got++;
                end
            end
            if (iv8 && rdy8) begin
                q8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8));
                sent++;
            end
        end
        chk("t4_count", 64'(got), 64'd5);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("t4_no_dup", 64'(ov8), 64'd0);

        // Reset with two ops in flight
        or8 = 1'b0;
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h01; sub8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        #1 chk("t5_inflight", 64'(ov8), 64'd1);
        rst = 1'b1;
        #1 chk("t5_rst_drop", 64'(ov8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        or8 = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            #1 if (ov8) stale++;
        end
        chk("t5_no_stale", 64'(stale), 64'd0);
        do_op8("t5_after_rst", 8'h40, 8'h02, 1'b1, 1'b0, res_t'{1'b0, 1'b0, 1'b0, 32'h43});

        // Random traffic on the wide pipes; last 30 cycles drain
        hx = 1'b0; hy = 1'b0; hvx = '0; hvy = '0;
        for (int i = 0; i < 3030; i++) begin
            @(negedge clk);
            ivx = (i < 3000) && ($urandom_range(0, 3) != 0);
            orx = (i >= 3000) || ($urandom_range(0, 3) != 0);
            ax = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
            bx = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            cinx = 1'($urandom); subx = 1'($urandom);
            ivy = (i < 3000) && ($urandom_range(0, 3) != 0);
            ory = (i >= 3000) || ($urandom_range(0, 3) != 0);
            ay = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            by = ($urandom_range(0, 7) == 0) ? ay : $urandom;
            ciny = 1'($urandom); suby = 1'($urandom);
            #1;
            obs = res_t'{zx, ovfx, cx, sx};
            if (hx) chk("x_hold", 64'({ovx, obs}), 64'({1'b1, hvx}));
            hx = ovx && !orx; hvx = obs;
            if (ovx && orx) begin
                if (qx.size() == 0) chk("x_extra", 64'(ovx), 64'd0);
                else chk("x_res", 64'(obs), 64'(qx.pop_front()));
            end
            if (ivx && rdyx) qx.push_back(model(32, ax, bx, cinx, subx));

            obs = res_t'{zy, ovfy, cy, sy};
            if (hy) chk("y_hold", 64'({ovy, obs}), 64'({1'b1, hvy}));
            hy = ovy && !ory; hvy = obs;
            if (ovy && ory) begin
                if (qy.size() == 0) chk("y_extra", 64'(ovy), 64'd0);
                else chk("y_res", 64'(obs), 64'(qy.pop_front()));
            end
            if (ivy && rdyy) qy.push_back(model(32, ay, by, ciny, suby));
        end
        chk("x_drained", 64'(qx.size()), 64'd0);
        chk("y_drained", 64'(qy.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
